// File: rtl/instr_mem_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals shared by the instruction
// memory arbiter and its environment.
interface instr_mem_arbiter_if #(
  parameter int WORD_LEN = 16,
  parameter int ADDR_W   = 8
);
  logic                f_req;
  logic [WORD_LEN-1:0] f_addr;
  logic                f_ack;
  logic [WORD_LEN-1:0] f_instr;
  logic                f_valid;
  logic                f_stall;

  logic                l_req;
  logic [ADDR_W-1:0]   l_addr;
  logic [7:0]          l_data;
  logic                l_ack;
  logic                l_done;

  logic [ADDR_W-1:0]   m_addr;
  logic                m_we;
  logic [7:0]          m_wdata;
  logic [WORD_LEN-1:0] m_rdata;

  logic                boot_busy;
  logic                err_misalign;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_data, l_done, m_rdata,
    output f_ack, f_instr, f_valid, f_stall, l_ack,
           m_addr, m_we, m_wdata, boot_busy, err_misalign
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_data, l_done, m_rdata,
    input  f_ack, f_instr, f_valid, f_stall, l_ack,
           m_addr, m_we, m_wdata, boot_busy, err_misalign
  );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Single-port instruction memory arbiter: boot loader owns the memory in BOOT,
// fetch has priority in RUN with a starvation guard for the loader.
module instr_mem_arbiter #(
  parameter int WORD_LEN   = 16,
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [WORD_LEN-1:0] f_instr_q, f_instr_d;
  logic                f_valid_q, f_valid_d;
  logic                err_q, err_d;

  logic                f_ack, l_ack;
  logic [ADDR_W-1:0]   f_cell;
  logic                unused_f_addr_hi;

  assign f_cell           = bus.f_addr[ADDR_W-1:0];
  assign unused_f_addr_hi = ^bus.f_addr[WORD_LEN-1:ADDR_W];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    f_ack = 1'b0;
    l_ack = 1'b0;
    if (rst) begin
      if (state_q == BOOT) begin
        l_ack = bus.l_req;
      end else if (bus.f_req && bus.l_req) begin
        // Loader wins only once it has waited STARVE_MAX cycles in a row.
        if (starve_q == CNT_W'(STARVE_MAX)) l_ack = 1'b1;
        else                                f_ack = 1'b1;
      end else begin
        f_ack = bus.f_req;
        l_ack = bus.l_req;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = '0;
    f_instr_d = f_instr_q;
    f_valid_d = f_ack;
    err_d     = err_q | (f_ack & bus.f_addr[0]);

    if (state_q == BOOT && bus.l_done) state_d = RUN;

    if (bus.l_req && !l_ack) begin
      starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q
                                                  : starve_q + CNT_W'(1);
    end

    if (f_ack) f_instr_d = bus.m_rdata;
  end

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked
  // branch; state updates use non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= BOOT;
      starve_q  <= '0;
      f_instr_q <= '0;
      f_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      f_instr_q <= f_instr_d;
      f_valid_q <= f_valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.f_ack        = f_ack;
  assign bus.l_ack        = l_ack;
  assign bus.f_stall      = bus.f_req & ~f_ack;
  assign bus.m_addr       = f_ack ? f_cell : (l_ack ? bus.l_addr : '0);
  assign bus.m_we         = l_ack;
  assign bus.m_wdata      = l_ack ? bus.l_data : 8'h00;
  assign bus.f_instr      = f_instr_q;
  assign bus.f_valid      = f_valid_q;
  assign bus.boot_busy    = (state_q == BOOT);
  assign bus.err_misalign = err_q;
endmodule
